// File: rtl/csd2bin_pipe_pkg.sv
// Shared definitions for the pipelined CSD-to-binary converter: digit codes and stage-count helper.
// Used by csd2bin_pipe (optional error detect via CSD2BIN_PIPE_ERR_EN).
package csd2bin_pipe_pkg;

    typedef enum logic [1:0] {
        CSD_ZERO = 2'b00,
        CSD_NEG  = 2'b01,
        CSD_POS  = 2'b10,
        CSD_INV  = 2'b11
    } csd_digit_e;

    // Ceiling divide used to derive the pipeline depth from W and CHUNK.
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/csd2bin_chunk.sv
// One combinational slice of the converter: resolves CW result bits of P + ~N + carry-in.
module csd2bin_chunk #(
    parameter int unsigned CW = 16
) (
    input  logic [CW-1:0] p,
    input  logic [CW-1:0] n,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    logic [CW-1:0] n_inv;

    // Invert at CW bits before widening so the extra carry bit stays zero.
    assign n_inv = ~n;
    assign {cout, sum} = (CW+1)'(p) + (CW+1)'(n_inv) + (CW+1)'(cin);

endmodule

// File: rtl/csd2bin_pipe.sv
// Pipelined CSD to two's-complement converter with valid/ready handshake, CHUNK bits per stage.
// Optional invalid-digit detection when CSD2BIN_PIPE_ERR_EN is defined; out_err is 0 otherwise.
module csd2bin_pipe
    import csd2bin_pipe_pkg::*;
#(
    parameter int unsigned W     = 73,
    parameter int unsigned CHUNK = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in_x,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_y,
    output logic           out_err
);

    localparam int unsigned NSTG = ceil_div(W, CHUNK);

    logic adv;

    logic [W-1:0] p_in;
    logic [W-1:0] n_in;

    logic [NSTG-1:0][W-1:0] p_d, n_d, y_d;
    logic [NSTG-1:0][W-1:0] p_q, n_q, y_q;
    logic [NSTG-1:0]        c_d, c_q, v_d, v_q;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[NSTG-1];
    assign out_y     = y_q[NSTG-1];

    // Split each digit into positive/negative weight bits; invalid codes count as zero.
    always_comb begin
        p_in = '0;
        n_in = '0;
        for (int i = 0; i < int'(W); i++) begin
            unique case (csd_digit_e'(in_x[2*i +: 2]))
                CSD_POS: p_in[i] = 1'b1;
                CSD_NEG: n_in[i] = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CSD2BIN_PIPE_ERR_EN
    logic            err_in;
    logic [NSTG-1:0] e_d, e_q;

    always_comb begin
        err_in = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            err_in = err_in | (&in_x[2*i +: 2]);
        end
    end

    assign out_err = e_q[NSTG-1];
`else
    assign out_err = 1'b0;
`endif

    for (genvar k = 0; k < int'(NSTG); k++) begin : g_stg
        localparam int unsigned LO = k * CHUNK;
        localparam int unsigned CW = ((W - LO) < CHUNK) ? (W - LO) : CHUNK;

        logic [W-1:0]  p_s, n_s, y_s, y_nx;
        logic          c_s, v_s;
        logic [CW-1:0] sum;
        logic          cout;

        if (k == 0) begin : g_first
            assign p_s = p_in;
            assign n_s = n_in;
            assign y_s = '0;
            assign c_s = 1'b1;
            assign v_s = in_valid;
`ifdef CSD2BIN_PIPE_ERR_EN
            assign e_d[k] = err_in;
`endif
        end else begin : g_next
            assign p_s = p_q[k-1];
            assign n_s = n_q[k-1];
            assign y_s = y_q[k-1];
            assign c_s = c_q[k-1];
            assign v_s = v_q[k-1];
`ifdef CSD2BIN_PIPE_ERR_EN
            assign e_d[k] = e_q[k-1];
`endif
        end

        csd2bin_chunk #(.CW(CW)) u_chunk (
            .p    (p_s[LO +: CW]),
            .n    (n_s[LO +: CW]),
            .cin  (c_s),
            .sum  (sum),
            .cout (cout)
        );

        // Resolved lower bits ride forward; this stage fills in its own chunk.
        always_comb begin
            y_nx          = y_s;
            y_nx[LO +: CW] = sum;
        end

        assign p_d[k] = p_s;
        assign n_d[k] = n_s;
        assign y_d[k] = y_nx;
        assign c_d[k] = cout;
        assign v_d[k] = v_s;
    end

    // All stages advance together; data registers only load behind a valid word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            p_q <= '0;
            n_q <= '0;
            y_q <= '0;
        end else if (adv) begin
            v_q <= v_d;
            for (int s = 0; s < int'(NSTG); s++) begin
                if (v_d[s]) begin
                    p_q[s] <= p_d[s];
                    n_q[s] <= n_d[s];
                    y_q[s] <= y_d[s];
                    c_q[s] <= c_d[s];
                end
            end
        end
    end

`ifdef CSD2BIN_PIPE_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
        end else if (adv) begin
            for (int s = 0; s < int'(NSTG); s++) begin
                if (v_d[s]) begin
                    e_q[s] <= e_d[s];
                end
            end
        end
    end
`endif

    // Already-resolved operand bits and the last carry are kept for regularity but never consumed.
    logic unused_bits;
    assign unused_bits = ^{p_q, n_q, c_q};

endmodule

// File: tb/tb_csd2bin_pipe.sv
// Directed and random bench for csd2bin_pipe at W=8/CHUNK=4 and W=73/CHUNK=16.
// Error-flag expectations follow CSD2BIN_PIPE_ERR_EN.
module tb_csd2bin_pipe;

`ifdef CSD2BIN_PIPE_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    localparam int NRAND = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_iv, a_ir, a_ov, a_or, a_e;
    logic [15:0] a_x;
    logic [7:0]  a_y;

    logic         b_iv, b_ir, b_ov, b_or, b_e;
    logic [145:0] b_x;
    logic [72:0]  b_y;

    int n_checks = 0;
    int n_errs   = 0;

    bit          mon_a = 1'b0;
    bit          mon_b = 1'b0;
    logic [7:0]  a_q[$];
    logic [72:0] b_q[$];
    logic        b_eq[$];
    logic [72:0] b_exp_y[$];
    logic        b_exp_e[$];

    csd2bin_pipe #(.W(8), .CHUNK(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_iv),
        .in_ready  (a_ir),
        .in_x      (a_x),
        .out_valid (a_ov),
        .out_ready (a_or),
        .out_y     (a_y),
        .out_err   (a_e)
    );

    csd2bin_pipe #(.W(73), .CHUNK(16)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_iv),
        .in_ready  (b_ir),
        .in_x      (b_x),
        .out_valid (b_ov),
        .out_ready (b_or),
        .out_y     (b_y),
        .out_err   (b_e)
    );

    // Record every output handshake; sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (mon_a && a_ov && a_or) a_q.push_back(a_y);
        if (mon_b && b_ov && b_or) begin
            b_q.push_back(b_y);
            b_eq.push_back(b_e);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present a word on A and return two time units after the edge that accepts it.
    task automatic send_a(input logic [15:0] x);
        int t;
        a_iv = 1'b1;
        a_x  = x;
        t    = 0;
        @(negedge clk);
        while (!a_ir && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_a", 128'(a_ir), 128'(1));
        step();
    endtask

    task automatic one_a(input string tag, input logic [15:0] x, input logic [7:0] ey, input logic ee);
        int lat;
        send_a(x);
        a_iv = 1'b0;
        lat  = 1;
        while (!a_ov && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(2));
        check({tag, "_y"}, 128'(a_y), 128'(ey));
        check({tag, "_err"}, 128'(a_e), 128'(ee));
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [15:0]  bp_x [4];
        logic [7:0]   bp_y [4];
        logic [145:0] x;
        logic [72:0]  p, n;
        int           t, cnt;

        rst  = 1'b1;
        a_iv = 1'b0; a_x = '0; a_or = 1'b1;
        b_iv = 1'b0; b_x = '0; b_or = 1'b1;
        #3;
        check("rst_a_ov", 128'(a_ov), 128'(0));
        check("rst_a_y", 128'(a_y), 128'(0));
        check("rst_a_err", 128'(a_e), 128'(0));
        check("rst_a_ir", 128'(a_ir), 128'(1));
        check("rst_b_ov", 128'(b_ov), 128'(0));
        check("rst_b_y", 128'(b_y), 128'(0));
        step();
        rst = 1'b0;
        step();

        // Directed single words, out_ready held high.
        one_a("pos1", 16'h0002, 8'h01, 1'b0);
        one_a("neg1", 16'h0001, 8'hFF, 1'b0);
        one_a("borrow", 16'h0201, 8'h0F, 1'b0);
        one_a("allneg", 16'h5555, 8'h01, 1'b0);
        one_a("allpos", 16'hAAAA, 8'hFF, 1'b0);
        one_a("msb_pos", 16'h8000, 8'h80, 1'b0);
        one_a("msb_neg", 16'h4000, 8'h80, 1'b0);
        one_a("inv", 16'h0030, 8'h00, ERR_ON);
        one_a("after_inv", 16'h0002, 8'h01, 1'b0);

        // Backpressure: stall 3 cycles with a full pipeline.
        bp_x[0] = 16'h0002; bp_y[0] = 8'h01;
        bp_x[1] = 16'h0201; bp_y[1] = 8'h0F;
        bp_x[2] = 16'hAAAA; bp_y[2] = 8'hFF;
        bp_x[3] = 16'h0808; bp_y[3] = 8'h22;
        a_q.delete();
        mon_a = 1'b1;
        send_a(bp_x[0]);
        send_a(bp_x[1]);
        a_or = 1'b0;
        a_iv = 1'b1;
        a_x  = bp_x[2];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ir", 128'(a_ir), 128'(0));
            check("stall_ov", 128'(a_ov), 128'(1));
            check("stall_y", 128'(a_y), 128'(bp_y[0]));
            step();
        end
        a_or = 1'b1;
        send_a(bp_x[2]);
        send_a(bp_x[3]);
        a_iv = 1'b0;
        t = 0;
        while (a_q.size() < 4 && t < 20) begin
            step();
            t++;
        end
        repeat (4) step();
        check("bp_count", 128'(a_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < a_q.size(); i++) begin
            check($sformatf("bp_y%0d", i), 128'(a_q[i]), 128'(bp_y[i]));
        end
        mon_a = 1'b0;

        // Reset with two words in flight.
        send_a(16'h0002);
        send_a(16'h0001);
        a_iv = 1'b0;
        rst  = 1'b1;
        #1;
        check("midrst_ov", 128'(a_ov), 128'(0));
        step();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_ov) cnt++;
        end
        check("midrst_stale", 128'(cnt), 128'(0));
        step();

        // Full-width stream against the P - N reference.
        b_q.delete();
        b_eq.delete();
        mon_b = 1'b1;
        for (int w = 0; w < NRAND; w++) begin
            if (w == 0) begin
                for (int i = 0; i < 73; i++) x[2*i +: 2] = 2'b01;
            end else if (w == 1) begin
                x = '0;
                x[145] = 1'b1;
            end else begin
                for (int i = 0; i < 146; i++) x[i] = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < 73; i++) begin
                p[i] = x[2*i+1];
                n[i] = x[2*i];
            end
            b_exp_y.push_back(p - n);
            b_exp_e.push_back(ERR_ON && (|(p & n)));
            b_iv = 1'b1;
            b_x  = x;
            step();
        end
        b_iv = 1'b0;
        t = 0;
        while (b_q.size() < NRAND && t < 40) begin
            step();
            t++;
        end
        repeat (6) step();
        check("rand_count", 128'(b_q.size()), 128'(NRAND));
        check("rand_w0", 128'(b_exp_y[0]), 128'(1));
        for (int i = 0; i < NRAND && i < b_q.size(); i++) begin
            check($sformatf("rand_y%0d", i), 128'(b_q[i]), 128'(b_exp_y[i]));
            check($sformatf("rand_e%0d", i), 128'(b_eq[i]), 128'(b_exp_e[i]));
        end
        mon_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
